clip_monitor: RTL and testbench
===============================

# clip_monitor

Clip/overload monitor for an unsigned offset-binary sample stream, normally placed after the saturating limiter stage. It flags samples at or beyond the configured limits, counts clip events over a fixed window of valid samples, and raises a held overload flag when a window's clip count reaches a threshold. An optional peak tracker reports per-window signed maximum and minimum.

## Interface
- N, 8, sample width in bits; N >= 2
- Lower, 8'h01, lower clip limit, offset-binary
- Upper, 8'hFE, upper clip limit, offset-binary; Upper > Lower in signed order
- W, 256, window length in valid samples; W >= 2
- Threshold, 8, clip count per window that triggers overload
- Hold, 16, overload hold time in clock cycles; Hold >= 1
- CW, 16, width of the clip counter and Count output

Ports:
- Clk  input  1  clock, rising edge
- nReset  input  1  reset, asynchronous, active-low
- Clear  input  1  synchronous restart of window, counters, peaks and overload
- Valid  input  1  Input carries a sample this cycle
- Input  input  N  sample, unsigned offset-binary
- Clip  output  1  registered per-sample clip flag
- Overload  output  1  held overload flag
- WindowDone  output  1  one-cycle pulse when a window closes
- Count  output  CW  clip count of the last completed window
- PeakMax  output  N  largest sample of last window, offset-binary
- PeakMin  output  N  smallest sample of last window, offset-binary

## Operation
- Comparisons are signed: invert MSB of Input, Lower and Upper, then compare as two's complement.
- Clip condition: t(Input) >= t(Upper) or t(Input) <= t(Lower). Limits themselves count as clipped.
- Window counter counts valid samples 0..W-1. A valid sample arriving at count W-1 closes the window and is included in it.
- Running clip counter increments on each clipped valid sample and saturates at 2^CW-1.
- At window close: Count <= final running count; running count <= 0; window counter <= 0; WindowDone pulses.
- Overload trigger: at window close with final count >= Threshold. Threshold = 0 triggers every window.
- Hold counter: loaded with Hold on trigger; otherwise decrements while non-zero. Overload = (hold counter != 0). A retrigger reloads the counter, so Overload stays continuous.
- Clear has priority over Valid:
  - Zeroes the window counter, running count and hold counter.
  - Resets the running peaks.
  - Count, PeakMax and PeakMin keep their values.
  - Clip and WindowDone read 0 in the following cycle.
- Reset values: Clip 0, Overload 0, WindowDone 0, Count 0, PeakMax and PeakMin midscale ({1'b1, zeros}). Running max resets to most negative (all zeros); running min resets to most positive (all ones).
- Valid low: no state change except hold-counter decrement. Clip is 0 in the following cycle.

## Timing
- Clip: registered; high the cycle after the clipped valid sample, for one cycle per sample.
- WindowDone, Count, PeakMax/PeakMin and the Overload rise all update on the same edge, one cycle after the closing sample.
- Overload stays high for exactly Hold cycles after the last trigger edge.
- Back-to-back valid samples every cycle are supported with no stalls.
- Asserting nReset at any point forces reset values immediately. Operation restarts with a fresh window on the first edge after release.

## Configuration
- CLIP_MONITOR_PEAK_EN defined: running max/min are tracked on every valid sample, including the closing sample. At window close they are transferred to PeakMax/PeakMin and the running values are reset.
- CLIP_MONITOR_PEAK_EN undefined: no peak logic is built. PeakMax and PeakMin are constant midscale. All other behaviour is unchanged.

## Test plan
All scenarios use default parameters and have CLIP_MONITOR_PEAK_EN defined unless stated.
- Reset: hold nReset low, then release. All outputs at reset values; PeakMax = PeakMin = 8'h80.
- Quiet window: 256 valid samples of 8'h80. WindowDone pulses one cycle after the 256th sample. Count = 0, Overload = 0, PeakMax = PeakMin = 8'h80.
- Overload: one window containing 4x 8'hFF, 4x 8'h00 and 248x 8'h80. Clip pulses 8 times, Count = 8, PeakMax = 8'hFF, PeakMin = 8'h00. Overload is high for exactly 16 cycles starting with WindowDone.
- Boundary and gaps: a window containing 7x 8'hFE and 249x 8'h02, with Valid low on every other cycle. Count = 7, Overload stays 0, window closes only after 256 valid samples.
- Clear mid-window: 100 samples of 8'hFF, then Clear, then 256 samples of 8'h80. Only one WindowDone occurs, at the end, with Count = 0. Count and PeakMax from the prior window are unchanged until then.
- Macro off: repeat the overload scenario with CLIP_MONITOR_PEAK_EN undefined. Count = 8 and Overload behaves identically, while PeakMax = PeakMin = 8'h80 throughout.

Source files
------------

// File: rtl/clip_monitor.sv
// rtl/clip_monitor.sv - clip/overload monitor over fixed windows of valid samples; peak tracker built only with CLIP_MONITOR_PEAK_EN
module clip_monitor #(
    parameter int           N         = 8,
    parameter logic [N-1:0] Lower     = N'(1),
    parameter logic [N-1:0] Upper     = {{(N-1){1'b1}}, 1'b0},
    parameter int           W         = 256,
    parameter int           Threshold = 8,
    parameter int           Hold      = 16,
    parameter int           CW        = 16
) (
    input  logic          Clk,
    input  logic          nReset,
    input  logic          Clear,
    input  logic          Valid,
    input  logic [N-1:0]  Input,
    output logic          Clip,
    output logic          Overload,
    output logic          WindowDone,
    output logic [CW-1:0] Count,
    output logic [N-1:0]  PeakMax,
    output logic [N-1:0]  PeakMin
);

    localparam int           WCW    = $clog2(W);
    localparam int           HW     = $clog2(Hold + 1);
    localparam logic [HW-1:0] HOLD_V = HW'(Hold);
    localparam logic [N-1:0] MID    = {1'b1, {(N-1){1'b0}}};

    // Offset-binary to two's complement: flip the MSB.
    function automatic logic signed [N-1:0] to_s(input logic [N-1:0] x);
        return {~x[N-1], x[N-2:0]};
    endfunction

    localparam logic signed [N-1:0] S_UP = to_s(Upper);
    localparam logic signed [N-1:0] S_LO = to_s(Lower);

    logic [WCW-1:0] win_cnt;
    logic [CW-1:0]  run_cnt;
    logic [HW-1:0]  hold_cnt;

    logic signed [N-1:0] s_in;
    logic                hit;
    logic                last;
    logic                close;
    logic [CW-1:0]       cnt_next;
    logic                trigger;

    assign s_in     = to_s(Input);
    assign hit      = Valid && ((s_in >= S_UP) || (s_in <= S_LO));
    assign last     = (win_cnt == WCW'(W - 1));
    assign close    = Valid && !Clear && last;
    assign cnt_next = (hit && (run_cnt != '1)) ? run_cnt + CW'(1) : run_cnt;
    assign trigger  = close && (cnt_next >= CW'(Threshold));
    assign Overload = (hold_cnt != '0);

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            win_cnt    <= '0;
            run_cnt    <= '0;
            hold_cnt   <= '0;
            Clip       <= 1'b0;
            WindowDone <= 1'b0;
            Count      <= '0;
        end else begin
            Clip       <= hit && !Clear;
            WindowDone <= close;
            if (Clear) begin
                win_cnt  <= '0;
                run_cnt  <= '0;
                hold_cnt <= '0;
            end else begin
                if (trigger)
                    hold_cnt <= HOLD_V;
                else if (hold_cnt != '0)
                    hold_cnt <= hold_cnt - HW'(1);
                if (Valid) begin
                    if (last) begin
                        win_cnt <= '0;
                        run_cnt <= '0;
                        Count   <= cnt_next;
                    end else begin
                        win_cnt <= win_cnt + WCW'(1);
                        run_cnt <= cnt_next;
                    end
                end
            end
        end
    end

`ifdef CLIP_MONITOR_PEAK_EN
    logic [N-1:0] run_max, run_min, pk_max, pk_min;
    logic [N-1:0] new_max, new_min;

    // The closing sample is folded in before the transfer to the outputs.
    assign new_max = (s_in > to_s(run_max)) ? Input : run_max;
    assign new_min = (s_in < to_s(run_min)) ? Input : run_min;

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            run_max <= '0;
            run_min <= '1;
            pk_max  <= MID;
            pk_min  <= MID;
        end else if (Clear) begin
            run_max <= '0;
            run_min <= '1;
        end else if (Valid) begin
            if (last) begin
                pk_max  <= new_max;
                pk_min  <= new_min;
                run_max <= '0;
                run_min <= '1;
            end else begin
                run_max <= new_max;
                run_min <= new_min;
            end
        end
    end

    assign PeakMax = pk_max;
    assign PeakMin = pk_min;
`else
    assign PeakMax = MID;
    assign PeakMin = MID;
`endif

endmodule

// File: tb/tb_clip_monitor.sv
// tb/tb_clip_monitor.sv - directed self-checking bench for clip_monitor
module tb_clip_monitor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        valid = 1'b0;
    logic [7:0]  din = 8'h00;
    logic        clip, overload, window_done;
    logic [15:0] count;
    logic [7:0]  peak_max, peak_min;

`ifdef CLIP_MONITOR_PEAK_EN
    localparam bit PEAK = 1'b1;
`else
    localparam bit PEAK = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    int clips = 0;
    int wds = 0;
    int ov = 0;

    clip_monitor dut (
        .Clk(clk), .nReset(rst_n), .Clear(clear), .Valid(valid), .Input(din),
        .Clip(clip), .Overload(overload), .WindowDone(window_done),
        .Count(count), .PeakMax(peak_max), .PeakMin(peak_min)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pk(input logic [7:0] v);
        return PEAK ? v : 8'h80;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        clips += int'(clip);
        wds   += int'(window_done);
    endtask

    task automatic send(input logic [7:0] v, input int n, input bit gap);
        for (int i = 0; i < n; i++) begin
            if (gap) begin
                valid = 1'b0;
                step();
            end
            valid = 1'b1;
            din   = v;
            step();
        end
        valid = 1'b0;
    endtask

    task automatic idle(input int n);
        valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic overload_window();
        send(8'hFF, 4, 1'b0);
        send(8'h00, 4, 1'b0);
        send(8'h80, 248, 1'b0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_clip", clip, 1'b0);
        check("rst_overload", overload, 1'b0);
        check("rst_wd", window_done, 1'b0);
        check("rst_count", count, 16'd0);
        check("rst_pmax", peak_max, 8'h80);
        check("rst_pmin", peak_min, 8'h80);
        #3 rst_n = 1'b1;
        step();

        clips = 0; wds = 0;
        send(8'h80, 256, 1'b0);
        check("quiet_wd", window_done, 1'b1);
        check("quiet_wds", wds, 1);
        check("quiet_clips", clips, 0);
        check("quiet_count", count, 16'd0);
        check("quiet_overload", overload, 1'b0);
        check("quiet_pmax", peak_max, pk(8'h80));
        check("quiet_pmin", peak_min, pk(8'h80));
        idle(1);
        check("quiet_wd_pulse", window_done, 1'b0);

        clips = 0; wds = 0;
        send(8'hFF, 4, 1'b0);
        send(8'h00, 4, 1'b0);
        check("ovl_pre_overload", overload, 1'b0);
        send(8'h80, 248, 1'b0);
        check("ovl_clips", clips, 8);
        check("ovl_wds", wds, 1);
        check("ovl_wd", window_done, 1'b1);
        check("ovl_count", count, 16'd8);
        check("ovl_overload", overload, 1'b1);
        check("ovl_pmax", peak_max, pk(8'hFF));
        check("ovl_pmin", peak_min, pk(8'h00));
        ov = int'(overload);
        for (int i = 0; i < 30; i++) begin
            step();
            ov += int'(overload);
        end
        check("ovl_hold_cycles", ov, 16);
        check("ovl_released", overload, 1'b0);

        overload_window();
        check("clr_ovl_set", overload, 1'b1);
        idle(3);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clr_ovl_cleared", overload, 1'b0);
        check("clr_ovl_count_kept", count, 16'd8);
        check("clr_ovl_pmax_kept", peak_max, pk(8'hFF));

        clips = 0; wds = 0;
        send(8'hFE, 7, 1'b1);
        send(8'h02, 248, 1'b1);
        check("gap_no_early_close", wds, 0);
        check("gap_count_kept", count, 16'd8);
        send(8'h02, 1, 1'b1);
        check("gap_wd", window_done, 1'b1);
        check("gap_wds", wds, 1);
        check("gap_clips", clips, 7);
        check("gap_count", count, 16'd7);
        check("gap_overload", overload, 1'b0);
        check("gap_pmax", peak_max, pk(8'hFE));
        check("gap_pmin", peak_min, pk(8'h02));

        clips = 0; wds = 0;
        send(8'hFF, 100, 1'b0);
        check("mid_clips", clips, 100);
        clear = 1'b1;
        valid = 1'b1;
        din   = 8'hFF;
        step();
        clear = 1'b0;
        valid = 1'b0;
        check("mid_clear_clip", clip, 1'b0);
        check("mid_clear_wd", window_done, 1'b0);
        wds = 0;
        send(8'h80, 255, 1'b0);
        check("mid_no_wd", wds, 0);
        check("mid_count_kept", count, 16'd7);
        check("mid_pmax_kept", peak_max, pk(8'hFE));
        send(8'h80, 1, 1'b0);
        check("mid_wd", window_done, 1'b1);
        check("mid_wds", wds, 1);
        check("mid_count", count, 16'd0);
        check("mid_overload", overload, 1'b0);
        check("mid_pmax", peak_max, pk(8'h80));
        check("mid_pmin", peak_min, pk(8'h80));

        overload_window();
        check("async_pre_count", count, 16'd8);
        #2 rst_n = 1'b0;
        #1;
        check("async_count", count, 16'd0);
        check("async_overload", overload, 1'b0);
        check("async_wd", window_done, 1'b0);
        check("async_pmax", peak_max, 8'h80);
        check("async_pmin", peak_min, 8'h80);
        #1 rst_n = 1'b1;
        wds = 0;
        send(8'h80, 255, 1'b0);
        check("fresh_no_wd", wds, 0);
        send(8'h80, 1, 1'b0);
        check("fresh_wd", window_done, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
